// File: rtl/pe_dispatch_pkg.sv
// Shared constants for the PE dispatcher: instruction field layout, hold-entry
// state encoding and a bit-width helper.
package pe_dispatch_pkg;

  localparam int INST_W      = 64;
  localparam int PE_ID_LSB   = 52;
  localparam int PE_ID_W     = 6;
  localparam int BARRIER_BIT = 60;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } hold_st_e;

  // Bits needed to hold any count from 0 to n inclusive.
  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pe_dispatch_mask_dec.sv
// Target-PE mask decoder: one-hot PE in single mode, a group of four PEs
// otherwise. Out-of-range ids produce an all-zero mask and valid_o=0.
module pe_mask_dec
  import pe_dispatch_pkg::*;
#(
  parameter int PE_NUM = 32
) (
  input  logic [PE_ID_W-1:0] pe_id_i,
  input  logic               single_i,
  output logic [PE_NUM-1:0]  mask_o,
  output logic               valid_o
);

  localparam int GRP_NUM = PE_NUM / 4;

  logic in_range_single;
  logic in_range_group;

  assign in_range_single = int'(pe_id_i) < PE_NUM;
  assign in_range_group  = int'(pe_id_i) < GRP_NUM;
  assign valid_o         = single_i ? in_range_single : in_range_group;

  // Equality per bit keeps out-of-range ids at zero without a wide shifter.
  genvar gi;
  generate
    for (gi = 0; gi < PE_NUM; gi++) begin : g_pe
      localparam int GRP_IDX = gi / 4;
      assign mask_o[gi] = single_i ? (int'(pe_id_i) == gi)
                                   : (int'(pe_id_i) == GRP_IDX);
    end
  endgenerate

endmodule

// File: rtl/pe_dispatch.sv
// In-order instruction scheduler in front of pe_array: one-entry hold register,
// per-PE busy scoreboard, local barrier retirement and statistic counters.
module pe_dispatch
  import pe_dispatch_pkg::*;
#(
  parameter int PE_NUM = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        layer_type_i,
  input  logic [INST_W-1:0] s_ins_i,
  input  logic              s_ins_valid_i,
  output logic              s_ins_ready_o,
  output logic [INST_W-1:0] m_ins_o,
  output logic              m_ins_valid_o,
  input  logic              m_ins_ready_i,
  input  logic [PE_NUM-1:0] pe_done_i,
  output logic [PE_NUM-1:0] busy_o,
  output logic              idle_o,
  output logic              barrier_done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  issued_cnt_o,
  output logic [CNT_W-1:0]  completed_cnt_o
);

  localparam int POP_W = bw(PE_NUM);

  hold_st_e          state_q, state_d, phase;
  logic [INST_W-1:0] hold_q, hold_d;
  logic [INST_W-1:0] m_ins_q, m_ins_d;
  logic              m_valid_q, m_valid_d;
  logic [PE_NUM-1:0] busy_q, busy_d;
  logic              err_q, err_d;
  logic              bdone_q, bdone_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  completed_q, completed_d;

  logic [PE_NUM-1:0] hold_mask;
  logic [PE_NUM-1:0] issue_mask;
  logic [PE_NUM-1:0] credited;
  logic [POP_W-1:0]  done_pop;
  logic              mask_ok;
  logic              is_barrier;
  logic              out_free;
  logic              go_issue;
  logic              go_barrier;
  logic              go_drop;
  logic              retire;
  logic              accept;
  logic              issue;
  logic              unused_layer;

  pe_mask_dec #(
    .PE_NUM (PE_NUM)
  ) u_mask_dec (
    .pe_id_i  (hold_q[PE_ID_LSB +: PE_ID_W]),
    .single_i (layer_type_i[0]),
    .mask_o   (hold_mask),
    .valid_o  (mask_ok)
  );

  assign unused_layer = ^layer_type_i[3:1];
  assign is_barrier   = hold_q[BARRIER_BIT];
  assign out_free     = !m_valid_q || m_ins_ready_i;
  assign credited     = pe_done_i & busy_q;

  // ISSUE is the entry's final cycle in WAIT: forwarding, scoreboard set and
  // retire all land on one edge, so the state register itself never holds it.
  always_comb begin : fsm_comb
    state_d    = state_q;
    hold_d     = hold_q;
    phase      = state_q;
    go_issue   = 1'b0;
    go_barrier = 1'b0;
    go_drop    = 1'b0;
    if (state_q == ST_WAIT) begin
      if (is_barrier) begin
        go_barrier = (busy_q == '0) && !m_valid_q;
      end else if (!mask_ok) begin
        go_drop = 1'b1;
      end else begin
        go_issue = ((hold_mask & busy_q) == '0) && out_free;
      end
    end
    if (go_issue) begin
      phase = ST_ISSUE;
    end
    retire        = go_issue || go_barrier || go_drop;
    s_ins_ready_o = (state_q == ST_EMPTY) || retire;
    accept        = s_ins_valid_i && s_ins_ready_o;
    if (accept) begin
      state_d = ST_WAIT;
      hold_d  = s_ins_i;
    end else if (retire) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin : datapath_comb
    issue       = (phase == ST_ISSUE);
    issue_mask  = issue ? hold_mask : '0;
    m_ins_d     = issue ? hold_q : m_ins_q;
    m_valid_d   = issue || (m_valid_q && !m_ins_ready_i);
    busy_d      = (busy_q & ~pe_done_i) | issue_mask;
    err_d       = err_q || go_drop || (|(pe_done_i & ~busy_q));
    bdone_d     = go_barrier;
    issued_d    = issued_q + CNT_W'(issue);
    done_pop    = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      done_pop = done_pop + POP_W'(credited[i]);
    end
    completed_d = completed_q + CNT_W'(done_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      hold_q      <= '0;
      m_ins_q     <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= '0;
      err_q       <= 1'b0;
      bdone_q     <= 1'b0;
      issued_q    <= '0;
      completed_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      m_ins_q     <= m_ins_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      bdone_q     <= bdone_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
    end
  end

  assign m_ins_o         = m_ins_q;
  assign m_ins_valid_o   = m_valid_q;
  assign busy_o          = busy_q;
  assign idle_o          = (state_q == ST_EMPTY) && !m_valid_q && (busy_q == '0);
  assign barrier_done_o  = bdone_q;
  assign err_o           = err_q;
  assign issued_cnt_o    = issued_q;
  assign completed_cnt_o = completed_q;

endmodule

// File: doc/pe_dispatch.md
Name: pe_dispatch

Overview:
- Instruction scheduler between the instruction fetch FIFO and pe_array.
- Decodes each instruction's target PE mask and keeps a per-PE busy scoreboard: set on issue, cleared on the PE's done pulse.
- Forwards an instruction only when every targeted PE is idle; executes barrier instructions locally.
- Prevents restarting a PE mid-operation and gives software a drain point before buffer switches.

Parameters:
- PE_NUM, 32, number of PEs; must be a multiple of 4.
- CNT_W, 16, width of the issued/completed statistic counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- layer_type  in  4  current layer mode; bit0=1 selects single-PE targeting, 0 selects group-of-4; stable while idle=0.
- s_ins  in  INST_W  instruction from fetch.
- s_ins_valid  in  1  s_ins valid.
- s_ins_ready  out  1  hold register can accept.
- m_ins  out  INST_W  instruction to pe_array.
- m_ins_valid  out  1  m_ins valid.
- m_ins_ready  in  1  pe_array accepts.
- pe_done  in  PE_NUM  per-PE single-cycle completion pulse.
- busy  out  PE_NUM  scoreboard.
- idle  out  1  hold empty, no output pending, busy==0.
- barrier_done  out  1  one-cycle pulse when a barrier retires.
- err  out  1  sticky error flag.
- issued_cnt  out  CNT_W  instructions forwarded (wraps).
- completed_cnt  out  CNT_W  done pulses counted (wraps).

Behaviour:
- Reset (rst=0, async): outputs/registers clear to 0: hold_valid, m_ins_valid, m_ins, busy, err, counters, barrier_done. Release is synchronous to clk.
- Instruction fields: pe_id=ins[57:52]; barrier op=ins[60].
- Decode mask:
  - layer_type[0]=1: 1<<pe_id.
  - Otherwise: 4'hF<<(4*pe_id).
  - Out-of-range: pe_id>=PE_NUM (single) or pe_id>=PE_NUM/4 (group) gives mask 0.
- Hold register: one entry. s_ins_ready = !hold_valid | retire_this_cycle. Accept on s_ins_valid & s_ins_ready.
- Output register: m_ins/m_ins_valid are registered. The value holds while m_ins_valid & !m_ins_ready. m_ins_valid drops the cycle after acceptance unless a new issue loads it.
- FSM on hold entry: EMPTY, WAIT, ISSUE.
  - EMPTY -> WAIT on accept.
  - Normal, WAIT: advance to ISSUE when (mask & busy)==0 and the output register is free (!m_ins_valid | m_ins_ready).
  - ISSUE: load m_ins, assert m_ins_valid next cycle, set busy|=mask, issued_cnt+1, retire.
  - Barrier: WAIT until busy==0 and !m_ins_valid. Then retire without forwarding, pulse barrier_done next cycle.
  - Mask 0, non-barrier: retire without forwarding, set err.
- Retire returns the FSM to EMPTY, or to WAIT if a new instruction is accepted the same cycle.
- Latency: accept at cycle T, earliest m_ins_valid at T+2.
- Busy check uses registered busy only; a done pulse arriving in cycle T allows issue at T+1.
- Scoreboard update: busy_next = (busy & ~pe_done) | issue_mask.
  - Set wins on the same bit. This can occur only for a spurious done on a non-busy PE.
  - pe_done on a non-busy PE sets err.
- completed_cnt += popcount(pe_done & busy) each cycle.
- Stall rules:
  - No bypass: a blocked instruction blocks all later ones (in-order).
  - Idle scoreboard bits do not change while blocked.
- layer_type change while idle=0: undefined for the dispatcher; the bench must not do it.
- Counters wrap modulo 2^CNT_W.
- err clears only on reset.

Decomposition:
- Shared package INS_CONST: INST_W, field positions PE_ID_LSB=52, PE_ID_W=6, BARRIER_BIT=60.
- Shared package GLOBAL_PARAM: bw().
- One sub-module: pe_mask_dec (pe_id, layer_type -> PE_NUM mask + valid flag), combinational, reused by the bench model.
- FSM, scoreboard and counters stay in pe_dispatch.

Test Plan:
- layer_type=1, issue pe_id=3 then pe_id=3 again, pe_done[3] at cycle 10 -> second m_ins_valid no earlier than cycle 11; busy=0x8 between.
- layer_type=0, pe_id=2 -> busy=0x00000F00; pe_id=2 again waits until all of pe_done[11:8] pulsed; completed_cnt=4.
- Barrier after two group issues (ids 0,1), done pulses staggered -> barrier_done exactly one cycle after busy reaches 0, never forwarded; issued_cnt=2.
- m_ins_ready held low 5 cycles with pe_id=5 queued -> m_ins stable, s_ins_ready low once hold full, no duplicate issue.
- pe_id=40 (single) and spurious pe_done[7] while idle -> instruction dropped, err=1, busy unchanged.
- Assert rst low mid-WAIT with busy=0xFF -> all outputs 0 immediately (async), busy=0, idle=1 after release.
